// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: shared opcode and FSM state enums plus instruction field offset helper for mc_cpu
package mc_cpu_pkg;
  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_ADDI  = 4'h6,
    OP_LOAD  = 4'h7,
    OP_STORE = 4'h8,
    OP_SHL   = 4'h9,
    OP_SHR   = 4'hA,
    OP_MUL   = 4'hB
  } opcode_t;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum int {F_IMM, F_RS2, F_RS1, F_RD, F_OP} field_t;
  function automatic int field_lsb(input int dw, input int rb, input field_t f);
    return f == F_IMM ? 0 : dw + (int'(f) - 1) * rb;
  endfunction
endpackage

// File: rtl/mc_cpu_alu.sv
// mc_cpu_alu: combinational ALU; ports op, a, b in, result/carry/zero out; MC_CPU_MUL_EN adds MUL (carry = high half nonzero)
module mc_cpu_alu
  import mc_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  zero
);
  localparam int DW = DATA_WIDTH;
  logic [DW:0] sum, dif;
  logic [DW-1:0] mul_y;
  logic mul_c, is_add;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign is_add = op == OP_ADD || op == OP_ADDI;
`ifdef MC_CPU_MUL_EN
  logic [2*DW-1:0] prod;
  assign prod = a * b;
  assign mul_y = prod[DW-1:0];
  assign mul_c = |prod[2*DW-1:DW];
`else
  assign mul_y = '0;
  assign mul_c = 1'b0;
`endif
  assign result = is_add        ? sum[DW-1:0] :
                  op == OP_SUB  ? dif[DW-1:0] :
                  op == OP_AND  ? a & b :
                  op == OP_OR   ? a | b :
                  op == OP_XOR  ? a ^ b :
                  op == OP_SHL  ? {a[DW-2:0], 1'b0} :
                  op == OP_SHR  ? {1'b0, a[DW-1:1]} :
                  op == OP_MUL  ? mul_y : '0;
  assign carry = is_add ? sum[DW] : op == OP_SUB ? dif[DW] : op == OP_MUL ? mul_c : 1'b0;
  assign zero = result == '0;
endmodule

// File: rtl/mc_cpu.sv
// mc_cpu: multicycle CPU (IDLE/DECODE/EXEC/MEM/WB); ports clk, rst (async high), instruction/instr_valid/instr_ready handshake, done/illegal WB pulses, zero_flag/carry_flag, out = flat regfile; MC_CPU_MUL_EN enables opcode B MUL
module mc_cpu
  import mc_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5,
  parameter int NUM_REGS   = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [4+3*$clog2(NUM_REGS)+DATA_WIDTH-1:0]           instruction,
  input  logic                                                 instr_valid,
  output logic                                                 instr_ready,
  output logic                                                 done,
  output logic                                                 illegal,
  output logic                                                 zero_flag,
  output logic                                                 carry_flag,
  output logic [NUM_REGS*DATA_WIDTH-1:0]                       out
);
  localparam int DW = DATA_WIDTH;
  localparam int RB = $clog2(NUM_REGS);
  localparam int IW = 4 + 3 * RB + DW;
  localparam int OP_LSB  = field_lsb(DW, RB, F_OP);
  localparam int RD_LSB  = field_lsb(DW, RB, F_RD);
  localparam int RS1_LSB = field_lsb(DW, RB, F_RS1);
  localparam int RS2_LSB = field_lsb(DW, RB, F_RS2);
`ifdef MC_CPU_MUL_EN
  localparam logic [3:0] OP_MAX = OP_MUL;
`else
  localparam logic [3:0] OP_MAX = OP_SHR;
`endif
  state_t state, state_n;
  logic [IW-1:0] ir;
  logic [DW-1:0] regs [NUM_REGS];
  logic [DW-1:0] mem [2**ADDR_BITS];
  logic [DW-1:0] a, b, imm, rdata, alu_b, alu_y;
  logic [ADDR_BITS-1:0] addr;
  logic [RB-1:0] rd, rs1, rs2;
  logic [3:0] opc;
  logic alu_c, alu_z, legal, writes_reg, sets_flags, mem_op;
  assign opc = ir[OP_LSB +: 4];
  assign rd  = ir[RD_LSB +: RB];
  assign rs1 = ir[RS1_LSB +: RB];
  assign rs2 = ir[RS2_LSB +: RB];
  assign imm = ir[DW-1:0];
  assign legal = opc <= OP_MAX;
  assign writes_reg = legal && opc != OP_NOP && opc != OP_STORE;
  assign sets_flags = writes_reg && opc != OP_LOAD;
  assign mem_op = opc == OP_LOAD || opc == OP_STORE;
  assign addr = ADDR_BITS'(a + imm);
  assign alu_b = opc == OP_ADDI ? imm : b;
  assign instr_ready = state == S_IDLE;
  assign done = state == S_WB;
  assign illegal = done && !legal;
  mc_cpu_alu #(.DATA_WIDTH(DW)) u_alu (
    .op     (opc),
    .a      (a),
    .b      (alu_b),
    .result (alu_y),
    .carry  (alu_c),
    .zero   (alu_z)
  );
  always_comb begin
    state_n = state == S_IDLE   ? (instr_valid ? S_DECODE : S_IDLE) :
              state == S_DECODE ? S_EXEC :
              state == S_EXEC   ? (mem_op ? S_MEM : S_WB) :
              state == S_MEM    ? S_WB : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= '0;
      a  <= '0;
      b  <= '0;
    end else begin
      if (state == S_IDLE && instr_valid) ir <= instruction;
      if (state == S_DECODE) begin
        a <= regs[rs1];
        b <= regs[rs2];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (state == S_WB) begin
      if (writes_reg) regs[rd] <= opc == OP_LOAD ? rdata : alu_y;
      if (sets_flags) begin
        zero_flag  <= alu_z;
        carry_flag <= alu_c;
      end
    end
  end
  // state is forced to IDLE asynchronously, so an interrupted MEM cycle never writes
  always_ff @(posedge clk) begin
    if (state == S_MEM) begin
      if (opc == OP_STORE) mem[addr] <= b;
      rdata <= mem[addr];
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign out[i*DW +: DW] = regs[i];
  end
endmodule
